// File: rtl/reduce_pkg.sv
// Shared definitions for the sequential bit-reduction unit.
// Optional feature: REDUCE_SEQ_XOR_EN enables the XOR (parity) operation.
package reduce_pkg;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Starting accumulator value: 1 for AND, 0 for OR/XOR/reserved.
    function automatic logic identity(input logic [1:0] op);
        return (op == OP_AND);
    endfunction

    // Two-input combine of the accumulator with a reduced chunk.
    // Without REDUCE_SEQ_XOR_EN, XOR and reserved fall back to OR.
    function automatic logic combine(input logic [1:0] op,
                                     input logic    x,
                                     input logic    y);
        logic r;
        r = x | y;
        if (op == OP_AND)
            r = x & y;
`ifdef REDUCE_SEQ_XOR_EN
        else if (op == OP_XOR)
            r = x ^ y;
`endif
        return r;
    endfunction

endpackage

// File: rtl/reduce_seq_if.sv
// Handshake bundle for reduce_seq: operand side (in_valid/in_ready/a/op)
// and result side (out_valid/out_ready/out). slave = unit, master = user.
interface reduce_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic             out;

    modport slave (
        input  in_valid, a, op, out_ready,
        output in_ready, out_valid, out
    );

    modport master (
        output in_valid, a, op, out_ready,
        input  in_ready, out_valid, out
    );
endinterface

// File: rtl/reduce_chunk.sv
// Combinational CHUNK-wide reduction of one operand slice.
// Ports: i_chunk (slice), i_op (operation), o_bit (reduced bit).
// REDUCE_SEQ_XOR_EN builds the XOR path; otherwise op 10 reduces as OR.
module reduce_chunk
    import reduce_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_chunk,
    input  logic [1:0]       i_op,
    output logic             o_bit
);

    always_comb begin
        o_bit = |i_chunk;
        if (i_op == OP_AND)
            o_bit = &i_chunk;
`ifdef REDUCE_SEQ_XOR_EN
        else if (i_op == OP_XOR)
            o_bit = ^i_chunk;
`endif
    end

endmodule

// File: rtl/reduce_seq.sv
// Multi-cycle reduction of a WIDTH-bit operand to one bit, CHUNK bits
// per clock, LSB chunk first. Ports: clk, rst (async, active-high),
// bus (reduce_seq_if.slave). REDUCE_SEQ_XOR_EN enables op 10 = XOR.
module reduce_seq
    import reduce_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    reduce_seq_if.slave  bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [1:0]       r_op;
    logic             r_acc;
    logic [IDXW-1:0]  r_idx;
    logic             r_out;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_shift;
    logic [CHUNK-1:0] w_chunk;
    logic             w_chunk_bit;
    logic             w_fold;
    logic             w_last;

    // Shift instead of a variable part-select keeps widths explicit.
    assign w_shift = r_a >> (32'(r_idx) * CHUNK);
    assign w_chunk = w_shift[CHUNK-1:0];
    assign w_last  = (r_idx == LAST);

    reduce_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_chunk (w_chunk),
        .i_op    (r_op),
        .o_bit   (w_chunk_bit)
    );

    assign w_fold = combine(r_op, r_acc, w_chunk_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid) w_next = BUSY;
            BUSY:    if (w_last) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_op        <= OP_OR;
            r_acc       <= 1'b0;
            r_idx       <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a   <= bus.a;
                        r_op  <= bus.op;
                        r_acc <= identity(bus.op);
                        r_idx <= '0;
                    end
                end
                BUSY: begin
                    r_acc <= w_fold;
                    r_idx <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_out       <= w_fold;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;

endmodule
